// File: rtl/muldiv_pkg.sv
// Shared types, constants and operation-decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    function automatic logic is_mul(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic is_signed_src1(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_src2(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide on a 2*XLEN accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              is_mul_op,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN+1:0] diff;
    logic            ge;

    // Multiply: {hi,lo} holds partial product over the unshifted multiplier.
    // Divide: {rem,quot} shifts the dividend into the remainder a bit at a time.
    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, operand};
        ge   = ~diff[XLEN+1];
        if (is_mul_op) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end else if (ge) begin
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execution unit: one result bit per cycle, valid/ready on both sides.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    state_e              state_r;
    logic [2:0]          op_r;
    logic                neg_r;
    logic [XLEN-1:0]     operand_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                out_valid_r;
    logic [XLEN-1:0]     out_result_r;

    logic                sgn1, sgn2, neg_s, special_s;
    logic [XLEN-1:0]     mag1, mag2, special_res;
    logic [2*XLEN-1:0]   step_next, prod;
    logic [XLEN-1:0]     div_val, final_res;

    assign in_ready   = (state_r == IDLE);
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_mul_op (is_mul(op_r)),
        .acc       (acc_r),
        .operand   (operand_r),
        .acc_next  (step_next)
    );

    // Accept-time decode: operand magnitudes, result sign, and the no-iteration divide cases.
    always_comb begin
        sgn1        = is_signed_src1(in_op) & in_src1[XLEN-1];
        sgn2        = is_signed_src2(in_op) & in_src2[XLEN-1];
        mag1        = sgn1 ? -in_src1 : in_src1;
        mag2        = sgn2 ? -in_src2 : in_src2;
        neg_s       = (in_op == OP_REM) ? sgn1 : (sgn1 ^ sgn2);
        special_s   = 1'b0;
        special_res = '0;
        if (!is_mul(in_op) && (in_src2 == '0)) begin
            special_s   = 1'b1;
            special_res = in_op[1] ? in_src1 : DIV0_QUOT;
        end else if (!is_mul(in_op) && is_signed_src1(in_op) &&
                     (in_src1 == INT_MIN) && (in_src2 == '1)) begin
            special_s   = 1'b1;
            special_res = in_op[1] ? '0 : INT_MIN;
        end else begin
            special_s   = 1'b0;
            special_res = '0;
        end
    end

    // Final-iteration result select with sign fix-up applied to the last step's output.
    always_comb begin
        prod    = neg_r ? -step_next : step_next;
        div_val = op_r[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
        if (is_mul(op_r)) begin
            final_res = (op_r == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            final_res = neg_r ? -div_val : div_val;
        end
    end

    // Control FSM and datapath registers; flush abandons work but keeps the last result value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            op_r         <= 3'b000;
            neg_r        <= 1'b0;
            operand_r    <= '0;
            acc_r        <= '0;
            cnt_r        <= '0;
            out_valid_r  <= 1'b0;
            out_result_r <= '0;
        end else if (flush) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r      <= in_op;
                        neg_r     <= neg_s;
                        operand_r <= mag2;
                        acc_r     <= {{XLEN{1'b0}}, mag1};
                        cnt_r     <= '0;
                        if (special_s) begin
                            out_result_r <= special_res;
                            out_valid_r  <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_r <= step_next;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(XLEN - 1)) begin
                        out_result_r <= final_res;
                        out_valid_r  <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven plus randomized self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_src1, in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference semantics from plain 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        int     ia = $signed(a);
        int     ib = $signed(b);
        longint p;
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic is_div = op[2];
        logic sgn    = ~op[0];
        if (is_div && ((b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Issue one request from IDLE; returns at #1 after the edge where out_valid rose (or budget).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_src1 = $urandom; in_src2 = $urandom; in_op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        seen;

        vecs[0]  = '{3'b000, 32'd7,          32'd6,          32'd42,         33};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,          32'd14,         33};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,          32'd2,          33};
        vecs[8]  = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[9]  = '{3'b111, 32'd5,          32'd0,          32'd5,          1};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[12] = '{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33};
        vecs[13] = '{3'b110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};

        reset_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_src1 = '0; in_src2 = '0;
        flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("reset_in_ready",   32'(in_ready),  32'd1);
        check("reset_out_valid",  32'(out_valid), 32'd0);
        check("reset_out_result", out_result,     32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i),  res,       vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat),  32'(vecs[i].lat));
            consume();
        end

        // Result hold while the consumer stalls.
        out_ready = 1'b0;
        run_op(3'b000, 32'd3, 32'd5, res, lat);
        check("hold_first_result", res, 32'd15);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_result", out_result,    32'd15);
            check("hold_in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready",  32'(in_ready),  32'd1);

        // Flush at iteration 10 with a competing request.
        in_valid = 1'b1; in_op = 3'b101; in_src1 = 32'd1000; in_src2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; in_op = 3'b000; in_src1 = 32'd9; in_src2 = 32'd9;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_in_ready",  32'(in_ready),  32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("flush_no_result", 32'(seen), 32'd0);

        // Reset at iteration 20.
        in_valid = 1'b1; in_op = 3'b000; in_src1 = 32'd11; in_src2 = 32'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midrst_in_ready",   32'(in_ready),  32'd1);
        check("midrst_out_valid",  32'(out_valid), 32'd0);
        check("midrst_out_result", out_result,     32'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("midrst_no_result", 32'(seen), 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            run_op(op, a, b, res, lat);
            check($sformatf("rand%0d_op%0d_%08h_%08h_result", i, op, a, b), res, model(op, a, b));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(model_lat(op, a, b)));
            consume();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
